// File: rtl/ram_peek_streamer.sv
// Sweeps a contiguous, wrapping word range of a node RAM through its peek port and streams it out.
// Optional running checksum of delivered words when RAM_STREAM_CHECKSUM_EN is defined.
module ram_peek_streamer #(
    parameter int RAM_SIZE   = 1024,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] word_count,
    output logic [31:0] peekAddress,
    input  logic [31:0] peekData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);
    localparam int CW = $clog2(RAM_SIZE) + 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        last;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   cur_addr_q, cur_addr_d;
    logic [CW-1:0] eff_q, eff_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [31:0]   peek_addr_q, peek_addr_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    entry_t        buf_q [FIFO_DEPTH];
    entry_t        buf_d [FIFO_DEPTH];
    logic          vld_q [FIFO_DEPTH];
    logic          vld_d [FIFO_DEPTH];

    logic          pop;
    logic [OW-1:0] occ;
    int            wr_idx;
    logic [CW-1:0] start_eff;
    logic [31:0]   start_addr;
    entry_t        push_entry;

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return (a == 32'(RAM_SIZE - 1)) ? 32'd0 : a + 32'd1;
    endfunction

    assign pop        = vld_q[0] && out_ready;
    assign start_eff  = (word_count > 32'(RAM_SIZE)) ? CW'(RAM_SIZE) : word_count[CW-1:0];
    assign start_addr = base_addr % 32'(RAM_SIZE);
    assign push_entry = '{data: peekData, addr: peek_addr_q, last: rd_last_q};

    always_comb begin
        occ = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) occ = occ + OW'(vld_q[i]);
        wr_idx = int'(occ) - int'(pop);
    end

    // Issue is counted against the buffer slots that will be free once this cycle's pop lands.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        eff_d       = eff_q;
        issued_d    = issued_q;
        peek_addr_d = peek_addr_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    eff_d = start_eff;
                    if (start_eff == '0) begin
                        state_d = FINISH;
                    end else begin
                        peek_addr_d = start_addr;
                        rd_valid_d  = 1'b1;
                        rd_last_d   = (start_eff == CW'(1));
                        cur_addr_d  = next_addr(start_addr);
                        issued_d    = CW'(1);
                        state_d     = (start_eff == CW'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if (int'(occ) + int'(rd_valid_q) - int'(pop) < FIFO_DEPTH) begin
                    peek_addr_d = cur_addr_q;
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (issued_q + CW'(1) == eff_q);
                    cur_addr_d  = next_addr(cur_addr_q);
                    issued_d    = issued_q + CW'(1);
                    if (issued_q + CW'(1) == eff_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_valid_q && (occ == '0 || (occ == OW'(1) && pop))) state_d = FINISH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift-register buffer: entry 0 is the registered stream output.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        entry_t nxt;
        logic   nxt_v;
        if (gi < FIFO_DEPTH - 1) begin : g_mid
            assign nxt   = buf_q[gi+1];
            assign nxt_v = vld_q[gi+1];
        end else begin : g_top
            assign nxt   = '0;
            assign nxt_v = 1'b0;
        end
        always_comb begin
            buf_d[gi] = pop ? nxt : buf_q[gi];
            vld_d[gi] = pop ? nxt_v : vld_q[gi];
            if (rd_valid_q && wr_idx == gi) begin
                buf_d[gi] = push_entry;
                vld_d[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            eff_q       <= '0;
            issued_q    <= '0;
            peek_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_q[i] <= '0;
                vld_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            eff_q       <= eff_d;
            issued_q    <= issued_d;
            peek_addr_q <= peek_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
                vld_q[i] <= vld_d[i];
            end
        end
    end

    assign peekAddress = peek_addr_q;
    assign out_valid   = vld_q[0];
    assign out_data    = buf_q[0].data;
    assign out_addr    = buf_q[0].addr;
    assign out_last    = buf_q[0].last;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FINISH);

`ifdef RAM_STREAM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) csum_d = '0;
        else if (pop)                 csum_d = csum_q + buf_q[0].data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif
endmodule
